// File: rtl/jpeg_quant_pkg.sv
// Shared types for the JPEG quantizer path: coefficient blocks, component ids,
// scheduler states and the MCU sequence helper.
package jpeg_quant_pkg;

  typedef logic signed [10:0] coeff_t;
  typedef coeff_t [0:7][0:7]  block_t;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUTPUT
  } qstate_t;

  // Block held for the quantizer: table select plus coefficients.
  typedef struct packed {
    comp_t  comp;
    block_t blk;
  } qreq_t;

  localparam int NUM_COMP = 3;
  localparam int SEQ_W    = 3;

  // Component expected at a given position inside the MCU.
  function automatic comp_t exp_comp(input logic [SEQ_W-1:0] idx, input int y_per_mcu);
    if (int'(idx) < y_per_mcu)       return COMP_Y;
    else if (int'(idx) == y_per_mcu) return COMP_CB;
    else                             return COMP_CR;
  endfunction

endpackage

// File: rtl/quant_watchdog.sv
// Cycle counter guarding the quantizer WAIT phase; pulses on expiry and keeps
// a saturating tally of expiries.
module quant_watchdog #(
  parameter int TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       run,
  input  logic       done,
  output logic       expired,
  output logic [7:0] err_count
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Completion in the expiry cycle wins, so no error is raised then.
  assign expired = run && !done && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      err_count <= '0;
    end else begin
      if (clear)
        cnt <= '0;
      else if (run && cnt != LAST)
        cnt <= cnt + 1'b1;
      if (expired && err_count != 8'hFF)
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: rtl/quant_scheduler.sv
// Time-shares one 8x8 quantizer across Y/Cb/Cr in strict MCU order, holding
// each result until the entropy stage takes it.
module quant_scheduler
  import jpeg_quant_pkg::*;
#(
  parameter int Y_PER_MCU = 4,
  parameter int TIMEOUT   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_COMP-1:0] in_valid,
  output logic [NUM_COMP-1:0] in_ready,
  input  block_t              Z_y,
  input  block_t              Z_cb,
  input  block_t              Z_cr,
  output logic                q_enable,
  output block_t              q_Z,
  output comp_t               q_comp,
  input  logic                q_out_enable,
  output logic                out_valid,
  output comp_t               out_comp,
  input  logic                out_ready,
  output logic                mcu_done,
  output logic                err_timeout,
  output logic [7:0]          err_count
);

  qstate_t          state, state_nxt;
  logic [SEQ_W-1:0] seq_idx;
  comp_t            exp_c;
  qreq_t            held;
  block_t           z_sel;
  logic             accept, seq_adv;
  logic             wd_clear, wd_run, wd_expired;

  assign exp_c = exp_comp(seq_idx, Y_PER_MCU);

  // Only the expected component can be granted; others wait their turn.
  for (genvar c = 0; c < NUM_COMP; c++) begin : g_rdy
    assign in_ready[c] = (state == IDLE) && (exp_c == comp_t'(c)) && in_valid[c];
  end
  assign accept = |in_ready;

  always_comb begin
    z_sel = Z_y;
    case (exp_c)
      COMP_CB: z_sel = Z_cb;
      COMP_CR: z_sel = Z_cr;
      default: z_sel = Z_y;
    endcase
  end

  always_comb begin
    state_nxt = state;
    q_enable  = 1'b0;
    out_valid = 1'b0;
    mcu_done  = 1'b0;
    seq_adv   = 1'b0;
    wd_clear  = 1'b0;
    wd_run    = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = ISSUE;
      ISSUE: begin
        q_enable  = 1'b1;
        wd_clear  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        wd_run = 1'b1;
        if (q_out_enable)
          state_nxt = OUTPUT;
        else if (wd_expired) begin
          seq_adv   = 1'b1;
          state_nxt = IDLE;
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          seq_adv   = 1'b1;
          mcu_done  = (held.comp == COMP_CR);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      seq_idx <= '0;
      held    <= '{comp: COMP_Y, blk: '0};
    end else begin
      state <= state_nxt;
      if (accept)
        held <= '{comp: exp_c, blk: z_sel};
      if (seq_adv)
        seq_idx <= (seq_idx == SEQ_W'(Y_PER_MCU + 1)) ? '0 : seq_idx + 1'b1;
    end
  end

  assign q_Z         = held.blk;
  assign q_comp      = held.comp;
  assign out_comp    = out_valid ? held.comp : COMP_Y;
  assign err_timeout = wd_expired;

  quant_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk       (clk),
    .rst       (rst),
    .clear     (wd_clear),
    .run       (wd_run),
    .done      (q_out_enable),
    .expired   (wd_expired),
    .err_count (err_count)
  );

endmodule

// File: tb/tb_quant_scheduler.sv
// Directed bench for quant_scheduler: MCU ordering, backpressure, watchdog,
// mid-flight reset and the 4:4:4 sequence.
module tb_quant_scheduler;
  import jpeg_quant_pkg::*;

  localparam int TO  = 32;
  localparam int LAT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 4:2:0
  logic       rst, q_enable, q_out_enable, out_valid, out_ready, mcu_done, err_timeout;
  logic [2:0] in_valid, in_ready;
  logic [7:0] err_count;
  block_t     z_y, z_cb, z_cr, q_z, zero_blk;
  comp_t      q_comp, out_comp;

  // DUT B: 4:4:4
  logic       rst1, q_enable1, q_out_enable1, out_valid1, out_ready1, mcu_done1, err_timeout1;
  logic [2:0] in_valid1, in_ready1;
  logic [7:0] err_count1;
  block_t     q_z1;
  comp_t      q_comp1, out_comp1;

  quant_scheduler #(.Y_PER_MCU(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Z_y(z_y), .Z_cb(z_cb), .Z_cr(z_cr),
    .q_enable(q_enable), .q_Z(q_z), .q_comp(q_comp), .q_out_enable(q_out_enable),
    .out_valid(out_valid), .out_comp(out_comp), .out_ready(out_ready),
    .mcu_done(mcu_done), .err_timeout(err_timeout), .err_count(err_count)
  );

  quant_scheduler #(.Y_PER_MCU(1), .TIMEOUT(TO)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
    .Z_y(z_y), .Z_cb(z_cb), .Z_cr(z_cr),
    .q_enable(q_enable1), .q_Z(q_z1), .q_comp(q_comp1), .q_out_enable(q_out_enable1),
    .out_valid(out_valid1), .out_comp(out_comp1), .out_ready(out_ready1),
    .mcu_done(mcu_done1), .err_timeout(err_timeout1), .err_count(err_count1)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_blk(input string tag, input block_t obs, input block_t expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic block_t zpick(input comp_t c);
    case (c)
      COMP_CB: return z_cb;
      COMP_CR: return z_cr;
      default: return z_y;
    endcase
  endfunction

  // Quantizer models: Q ready LAT cycles after the start pulse.
  int   qcnt, qcnt1;
  logic q_model_en, q_oe_force;
  always @(posedge clk) begin
    if (rst)             qcnt <= 0;
    else if (q_enable)   qcnt <= LAT;
    else if (qcnt > 0)   qcnt <= qcnt - 1;
  end
  assign q_out_enable = (q_model_en && qcnt == 1) || q_oe_force;

  always @(posedge clk) begin
    if (rst1)            qcnt1 <= 0;
    else if (q_enable1)  qcnt1 <= 2;
    else if (qcnt1 > 0)  qcnt1 <= qcnt1 - 1;
  end
  assign q_out_enable1 = (qcnt1 == 1);

  // Scoreboard for DUT A: expected block pushed on accept, popped on handshake/timeout.
  qreq_t sb[$];
  int    rlog[$];
  comp_t qlog[$];
  int    m_idx = 0;
  bit    m_busy = 0, qen_due = 0;
  int    ra_cnt = 0, hs_cnt = 0, qen_cnt = 0, err_seen = 0, mcu_cnt = 0;
  int    acc_cyc = 0, hs_cyc = 0, qen_cyc = 0, err_cyc = 0;

  always @(negedge clk) begin
    comp_t      e;
    logic [2:0] rdy_exp;
    bit         hs;
    if (rst) begin
      sb.delete();
      m_idx = 0; m_busy = 0; qen_due = 0;
    end else begin
      e = (m_idx < 4) ? COMP_Y : (m_idx == 4) ? COMP_CB : COMP_CR;
      rdy_exp = (!m_busy && in_valid[e]) ? (3'b001 << e) : 3'b000;
      chk("in_ready", 32'(in_ready), 32'(rdy_exp));
      chk("q_enable", 32'(q_enable), 32'(qen_due));
      qen_due = 0;
      if (q_enable) begin
        qen_cnt++; qen_cyc = cyc; qlog.push_back(q_comp);
        if (sb.size() > 0) begin
          chk("q_comp", 32'(q_comp), 32'(sb[0].comp));
          chk_blk("q_z", q_z, sb[0].blk);
        end
      end
      hs = out_valid && out_ready;
      if (sb.size() == 0) begin
        chk("out_valid_idle", 32'(out_valid), 32'(0));
        chk("err_idle", 32'(err_timeout), 32'(0));
      end else begin
        if (out_valid) chk("out_comp", 32'(out_comp), 32'(sb[0].comp));
        chk("mcu_done", 32'(mcu_done), 32'(hs && sb[0].comp == COMP_CR));
        if (hs || err_timeout) begin
          if (hs) begin hs_cnt++; hs_cyc = cyc; if (mcu_done) mcu_cnt++; end
          if (err_timeout) begin err_seen++; err_cyc = cyc; end
          void'(sb.pop_front());
          m_busy = 0;
          m_idx  = (m_idx == 5) ? 0 : m_idx + 1;
        end
      end
      for (int c = 0; c < 3; c++)
        if (in_ready[c] && in_valid[c]) begin rlog.push_back(c); ra_cnt++; acc_cyc = cyc; end
      if (in_ready[e] && in_valid[e]) begin
        sb.push_back('{comp: e, blk: zpick(e)});
        m_busy = 1; qen_due = 1;
      end
    end
  end

  // DUT B handshake log
  comp_t log1_comp[$];
  logic  log1_mcu[$];
  always @(negedge clk)
    if (!rst1 && out_valid1 && out_ready1) begin
      log1_comp.push_back(out_comp1);
      log1_mcu.push_back(mcu_done1);
    end

  task automatic wait_acc(input int target, input int budget, input string tag);
    int n = 0;
    while (ra_cnt < target && n < budget) begin tick(); n++; end
    chk(tag, 32'(ra_cnt), 32'(target));
  endtask

  task automatic wait_hs(input int target, input int budget, input string tag);
    int n = 0;
    while (hs_cnt < target && n < budget) begin tick(); n++; end
    chk(tag, 32'(hs_cnt), 32'(target));
  endtask

  task automatic wait_err(input int target, input int budget, input string tag);
    int n = 0;
    while (err_seen < target && n < budget) begin tick(); n++; end
    chk(tag, 32'(err_seen), 32'(target));
  endtask

  initial begin
    int    a0, q0, h0, e0, n;
    comp_t exp_ord[6];
    comp_t exp1[6];
    logic  exp1_mcu[6];
    exp_ord = '{COMP_Y, COMP_Y, COMP_Y, COMP_Y, COMP_CB, COMP_CR};
    exp1    = '{COMP_Y, COMP_CB, COMP_CR, COMP_Y, COMP_CB, COMP_CR};
    exp1_mcu = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    zero_blk = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        z_y[r][c]  = coeff_t'(r * 8 + c);
        z_cb[r][c] = coeff_t'(-(r * 8 + c) - 1);
        z_cr[r][c] = coeff_t'(300 + r * 3 + c);
      end
    rst = 1'b1; in_valid = '0; out_ready = 1'b1; q_model_en = 1'b1; q_oe_force = 1'b0;
    rst1 = 1'b1; in_valid1 = '0; out_ready1 = 1'b1;

    // Reset state
    repeat (2) tick();
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_q_enable", 32'(q_enable), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_q_comp", 32'(q_comp), 32'(COMP_Y));
    chk_blk("rst_q_z", q_z, zero_blk);
    chk("rst_err_count", 32'(err_count), 32'(0));
    rst = 1'b0;
    tick();

    // MCU order with all components requesting
    in_valid = 3'b111;
    wait_hs(6, 200, "order_hs");
    in_valid = 3'b000;
    chk("order_n", 32'(qlog.size()), 32'(6));
    for (int i = 0; i < 6 && i < qlog.size(); i++) begin
      chk("order_q_comp", 32'(qlog[i]), 32'(exp_ord[i]));
      chk("order_accept", 32'(rlog[i]), 32'(exp_ord[i]));
    end
    chk("order_mcu_done", 32'(mcu_cnt), 32'(1));

    // Out-of-order requester is never granted
    in_valid = 3'b100; a0 = ra_cnt; q0 = qen_cnt;
    repeat (50) tick();
    chk("ooo_no_accept", 32'(ra_cnt), 32'(a0));
    chk("ooo_no_qen", 32'(qen_cnt), 32'(q0));
    in_valid = 3'b101;
    wait_acc(a0 + 1, 20, "ooo_y_accept");
    in_valid = 3'b000;
    chk("ooo_y_comp", 32'(rlog[rlog.size()-1]), 32'(COMP_Y));
    wait_hs(hs_cnt + 1, 50, "ooo_hs");

    // Backpressure
    out_ready = 1'b0; in_valid = 3'b001;
    wait_acc(ra_cnt + 1, 20, "bp_accept");
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("bp_out_valid", 32'(out_valid), 32'(1));
    a0 = ra_cnt; q0 = qen_cnt;
    repeat (20) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'(1));
      chk("bp_hold_comp", 32'(out_comp), 32'(COMP_Y));
    end
    chk("bp_no_qen", 32'(qen_cnt), 32'(q0));
    chk("bp_no_accept", 32'(ra_cnt), 32'(a0));
    out_ready = 1'b1;
    wait_acc(a0 + 1, 20, "bp_next_accept");
    in_valid = 3'b000;
    chk("bp_gap", 32'(acc_cyc - hs_cyc), 32'(1));
    wait_hs(hs_cnt + 1, 50, "bp_hs");

    // Watchdog expiry (seq idx 3, Y)
    q_model_en = 1'b0; in_valid = 3'b001; e0 = err_seen;
    wait_acc(ra_cnt + 1, 20, "to_accept");
    in_valid = 3'b000;
    wait_err(e0 + 1, 80, "to_err");
    chk("to_delta", 32'(err_cyc - qen_cyc), 32'(TO));
    tick();
    chk("to_err_count", 32'(err_count), 32'(1));
    chk("to_out_valid", 32'(out_valid), 32'(0));

    // Dropped Y skips ahead to Cb; completion in the expiry cycle wins
    in_valid = 3'b111; h0 = hs_cnt; e0 = err_seen;
    wait_acc(ra_cnt + 1, 20, "to_next_accept");
    in_valid = 3'b000;
    chk("to_next_comp", 32'(q_comp), 32'(COMP_CB));
    tick();
    n = 0;
    while (cyc < qen_cyc + TO && n < 80) begin tick(); n++; end
    q_oe_force = 1'b1;
    tick();
    q_oe_force = 1'b0;
    chk("race_out_valid", 32'(out_valid), 32'(1));
    wait_hs(h0 + 1, 10, "race_hs");
    chk("race_no_err", 32'(err_seen), 32'(e0));
    chk("race_err_count", 32'(err_count), 32'(1));

    // Finish the MCU with Cr
    q_model_en = 1'b1; in_valid = 3'b111; a0 = mcu_cnt;
    wait_hs(hs_cnt + 1, 50, "cr_hs");
    in_valid = 3'b000;
    chk("cr_mcu_done", 32'(mcu_cnt), 32'(a0 + 1));

    // Reset while waiting on the quantizer
    q_model_en = 1'b0; in_valid = 3'b001;
    wait_acc(ra_cnt + 1, 20, "rw_accept");
    in_valid = 3'b000;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_q_enable", 32'(q_enable), 32'(0));
    chk("rw_out_valid", 32'(out_valid), 32'(0));
    chk("rw_out_comp", 32'(out_comp), 32'(0));
    chk("rw_mcu_done", 32'(mcu_done), 32'(0));
    chk("rw_err_timeout", 32'(err_timeout), 32'(0));
    chk("rw_err_count", 32'(err_count), 32'(0));
    chk("rw_q_comp", 32'(q_comp), 32'(COMP_Y));
    chk_blk("rw_q_z", q_z, zero_blk);
    q_oe_force = 1'b1;
    tick();
    q_oe_force = 1'b0;
    chk("rw_late_oe", 32'(out_valid), 32'(0));
    tick();
    chk("rw_late_oe2", 32'(out_valid), 32'(0));
    in_valid = 3'b110; a0 = ra_cnt;
    repeat (5) tick();
    chk("rw_no_cbcr", 32'(ra_cnt), 32'(a0));
    q_model_en = 1'b1; in_valid = 3'b111;
    wait_acc(a0 + 1, 20, "rw_y_accept");
    in_valid = 3'b000;
    chk("rw_y_comp", 32'(q_comp), 32'(COMP_Y));
    wait_hs(hs_cnt + 1, 50, "rw_hs");

    // 4:4:4 sequence
    rst1 = 1'b0; in_valid1 = 3'b111;
    n = 0;
    while (log1_comp.size() < 6 && n < 200) begin tick(); n++; end
    in_valid1 = 3'b000;
    chk("y1_n", 32'(log1_comp.size() >= 6), 32'(1));
    for (int i = 0; i < 6 && i < log1_comp.size(); i++) begin
      chk("y1_comp", 32'(log1_comp[i]), 32'(exp1[i]));
      chk("y1_mcu", 32'(log1_mcu[i]), 32'(exp1_mcu[i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quant_scheduler.md
Name: quant_scheduler

Overview:
- Sequences the single shared 8x8 quantizer core across the Y, Cb and Cr DCT streams, in strict MCU order.
- Accepts one 11-bit signed coefficient block per valid/ready handshake from the expected component.
- Registers the accepted block, fires a one-cycle enable plus table select into the quantizer, and waits for its out_enable.
- Holds the result for the downstream entropy stage until accepted; a watchdog covers a hung core.

Parameters:
- Y_PER_MCU, 4, Y blocks per MCU: 4 = 4:2:0, 1 = 4:4:4. Legal values are 1..4.
- TIMEOUT, 32, maximum cycles in WAIT before a dropped-block error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  3  per-component block valid, index = comp_t
- in_ready  out  3  per-component accept strobe
- Z_y, Z_cb, Z_cr  in  [0:7][0:7]x11 signed  DCT blocks per component
- q_enable  out  1  one-cycle start pulse to the quantizer
- q_Z  out  [0:7][0:7]x11 signed  registered block driven to the quantizer
- q_comp  out  2  table select (comp_t); stable from q_enable through the output handshake
- q_out_enable  in  1  quantizer completion
- out_valid  out  1  quantizer Q is valid for downstream
- out_comp  out  2  component of the current output block
- out_ready  in  1  downstream accept
- mcu_done  out  1  one-cycle pulse when the last block of an MCU is accepted downstream
- err_timeout  out  1  one-cycle pulse on watchdog expiry
- err_count  out  8  saturating count of timeouts

Behaviour:
- Reset (sync, rst=1 at a clk edge) applies regardless of state, including mid-operation:
  - state=IDLE, seq_idx=0, q_Z all 0, q_comp=COMP_Y;
  - all outputs 0, err_count=0;
  - a pending quantizer result is discarded.
- Sequence:
  - seq_idx runs 0..Y_PER_MCU+1.
  - Expected component: COMP_Y for idx<Y_PER_MCU, COMP_CB for idx=Y_PER_MCU, COMP_CR for idx=Y_PER_MCU+1.
  - seq_idx wraps to 0 after the Cr block.
- IDLE:
  - in_ready[exp] = in_valid[exp]; all other in_ready bits stay 0. Non-expected valids are ignored and never reordered.
  - On in_valid[exp]: capture the matching Z into q_Z, set q_comp=exp, go to ISSUE.
- ISSUE: q_enable=1 for exactly one cycle; clear the watchdog counter; go to WAIT. q_enable follows the accept cycle by 1 cycle.
- WAIT:
  - Counter increments each cycle.
  - If q_out_enable=1: go to OUTPUT.
  - Else if counter reaches TIMEOUT-1: err_timeout=1 for 1 cycle, err_count+=1 (saturates at 255), seq_idx advances (block dropped), go to IDLE.
  - q_out_enable wins if both occur in the same cycle.
- OUTPUT:
  - out_valid=1 and out_comp=q_comp, held until out_ready=1.
  - On the handshake: advance seq_idx; if the block was Cr, mcu_done=1 that cycle; go to IDLE.
  - out_ready already high when out_valid rises completes the handshake in that same cycle.
- No q_enable is issued while in OUTPUT, so the quantizer's Q stays stable until downstream accepts it.
- q_out_enable outside WAIT is ignored.
- Next accept comes no earlier than the cycle after the output handshake. Minimum per block: 3 cycles + quantizer latency.
- q_Z and q_comp change only on an IDLE accept or on reset.

Decomposition:
- Shared package jpeg_quant_pkg (add to it if it already exists) holds:
  - typedef coeff_t (logic signed [10:0]);
  - typedef block_t (coeff_t [0:7][0:7]);
  - enum comp_t {COMP_Y=0, COMP_CB=1, COMP_CR=2};
  - state enum {IDLE, ISSUE, WAIT, OUTPUT}.
- One natural sub-module: quant_watchdog, with clear, count, TIMEOUT compare, expired pulse and saturating err_count.
- The main FSM, sequence counter and q_Z register stay in quant_scheduler.

Test Plan:
- Order, Y_PER_MCU=4, quantizer model latency 5: all three in_valid held high with distinct ramps -> in_ready pulses Y,Y,Y,Y,Cb,Cr. q_comp on each q_enable is 0,0,0,0,1,2. q_enable 1 cycle after each accept. mcu_done exactly once, on the Cr handshake.
- Out-of-order requester: only in_valid[COMP_CR] high at idx 0 for 50 cycles -> in_ready stays 000 and no q_enable. Then raise Y -> Y accepted.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_valid and out_comp held and no new q_enable. Next accept occurs ≥1 cycle after out_ready=1.
- Timeout, TIMEOUT=32: q_out_enable never asserted -> err_timeout pulses at cycle 32 after q_enable, err_count=1, next accept expects the following component. q_out_enable asserted in the expiry cycle -> OUTPUT and no error.
- Reset mid-WAIT: rst=1 for 1 cycle while waiting -> next cycle all outputs 0 and seq_idx=0. A late q_out_enable is ignored and the next accept expects Y.
- Y_PER_MCU=1: continuous valids -> order Y,Cb,Cr,Y,Cb,Cr with mcu_done every third handshake.
